// File: rtl/key_debounce_if.sv
// Key bundle between the board pins and the debouncer: raw active-low pins in,
// debounced levels and one-cycle press/release pulses out.
interface key_debounce_if;
  logic [3:0] key_n;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;

  modport master (
    output key_n,
    input  key_state,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_n,
    output key_state,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Four-channel push-button conditioner: 2-flop synchroniser, per-key stability
// counter and FSM, registered debounced level plus press/release pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  key_debounce_if.slave keys
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic [3:0]       sync_a_r;
  logic [3:0]       sync_b_r;
  logic [3:0]       pressed_s;
  logic [1:0]       state_r [4];
  logic [1:0]       state_s [4];
  logic [CNT_W-1:0] cnt_r   [4];
  logic [CNT_W-1:0] cnt_s   [4];
  logic [3:0]       level_r;
  logic [3:0]       level_s;
  logic [3:0]       press_r;
  logic [3:0]       press_s;
  logic [3:0]       release_r;
  logic [3:0]       release_s;

  assign pressed_s = ~sync_b_r;

  // Per-key next-state logic. Completing the count wins over a same-cycle
  // change so that an excursion of exactly DEBOUNCE_CYCLES samples is accepted.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    level_s   = level_r;
    press_s   = 4'b0000;
    release_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      case (state_r[k])
        ST_IDLE: begin
          if (pressed_s[k]) begin
            state_s[k] = ST_PRESS_WAIT;
            cnt_s[k]   = CNT_ZERO;
          end else begin
            state_s[k] = ST_IDLE;
          end
        end
        ST_PRESS_WAIT: begin
          if (cnt_r[k] == CNT_LAST) begin
            state_s[k] = ST_PRESSED;
            level_s[k] = 1'b1;
            press_s[k] = 1'b1;
          end else if (!pressed_s[k]) begin
            state_s[k] = ST_IDLE;
          end else begin
            cnt_s[k] = cnt_r[k] + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!pressed_s[k]) begin
            state_s[k] = ST_RELEASE_WAIT;
            cnt_s[k]   = CNT_ZERO;
          end else begin
            state_s[k] = ST_PRESSED;
          end
        end
        ST_RELEASE_WAIT: begin
          if (cnt_r[k] == CNT_LAST) begin
            state_s[k]   = ST_IDLE;
            level_s[k]   = 1'b0;
            release_s[k] = 1'b1;
          end else if (pressed_s[k]) begin
            state_s[k] = ST_PRESSED;
          end else begin
            cnt_s[k] = cnt_r[k] + CNT_ONE;
          end
        end
        default: begin
          state_s[k] = ST_IDLE;
          cnt_s[k]   = CNT_ZERO;
          level_s[k] = 1'b0;
        end
      endcase
    end
  end

  // Synchroniser, FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_r  <= 4'b1111;
      sync_b_r  <= 4'b1111;
      level_r   <= 4'b0000;
      press_r   <= 4'b0000;
      release_r <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        state_r[k] <= ST_IDLE;
        cnt_r[k]   <= CNT_ZERO;
      end
    end else begin
      sync_a_r  <= keys.key_n;
      sync_b_r  <= sync_a_r;
      level_r   <= level_s;
      press_r   <= press_s;
      release_r <= release_s;
      state_r   <= state_s;
      cnt_r     <= cnt_s;
    end
  end

  assign keys.key_state   = level_r;
  assign keys.key_press   = press_r;
  assign keys.key_release = release_r;

endmodule

// File: doc/key_debounce.md
# key_debounce

Four-channel push-button conditioner that sits directly upstream of the LED sequencer on the board's user keys. It synchronises the raw active-low key pins into the system clock domain, rejects contact bounce with a per-key stability counter and FSM, and presents debounced levels plus single-cycle press and release pulses. The LED sequencer and later control logic use these outputs for mode and speed changes.

## Interface

**Parameters**

- `DEBOUNCE_CYCLES`, default 1000000. Number of consecutive stable cycles required to accept a change (20 ms at 50 MHz). Legal range: ≥ 2.
- `CNT_W`, localparam, equal to `$clog2(DEBOUNCE_CYCLES)`. Width of each per-key counter.

**Ports**

- `clk`, input, 1. System clock. Single clock domain.
- `rst`, input, 1. Synchronous, active-high reset.
- `key_n`, input, 4. Raw key pins, active-low (0 = pressed). Asynchronous to `clk`.
- `key_state`, output, 4. Debounced level, active-high (1 = pressed).
- `key_press`, output, 4. One-cycle pulse per key on an accepted press.
- `key_release`, output, 4. One-cycle pulse per key on an accepted release.

## Operation

**Synchroniser**

- Each key uses a 2-flop synchroniser.
- The synchronised value is inverted into `pressed_s[i]` (1 = pressed).
- Both flops reset to 1 (released).

**Per-key FSM** (four independent instances, each with its own `CNT_W`-bit counter `cnt`)

- IDLE: key stable released.
  - `pressed_s = 1`: go to PRESS_WAIT, `cnt <= 0`.
- PRESS_WAIT:
  - `pressed_s = 0`: go to IDLE. Glitch rejected; no pulse; `key_state` stays 0.
  - `cnt == DEBOUNCE_CYCLES-1`: go to PRESSED. `key_state <= 1`, `key_press <= 1` for one cycle.
  - Otherwise: `cnt <= cnt + 1`.
- PRESSED:
  - `pressed_s = 0`: go to RELEASE_WAIT, `cnt <= 0`.
- RELEASE_WAIT:
  - `pressed_s = 1`: go to PRESSED. No pulse; `key_state` stays 1.
  - `cnt == DEBOUNCE_CYCLES-1`: go to IDLE. `key_state <= 0`, `key_release <= 1` for one cycle.
  - Otherwise: `cnt <= cnt + 1`.

**Counter rules**

- `cnt` only advances in the wait states.
- `cnt` never wraps. Compare-equal at `DEBOUNCE_CYCLES-1` always exits the wait state first.
- A bounce restarts counting from 0 on the next entry to a wait state.

**Output rules**

- All outputs are registered.
- `key_press[i]` and `key_release[i]` are never high in the same cycle.
- Neither pulse lasts longer than one cycle.

**Independence**

- Keys share no state.
- Any combination of keys may pulse in the same cycle.

## Timing

**Reset**

- `rst` high at a clock edge forces every FSM to IDLE.
- All `cnt` values go to 0 and the synchroniser flops go to 1.
- `key_state`, `key_press` and `key_release` all go to 4'b0000.
- Reset applies regardless of the current state. A pulse due in the same cycle is suppressed.

**Press latency**

- Let edge 0 be the first edge at which `key_n[i] = 0` is sampled, with the key held low continuously.
- The FSM enters PRESS_WAIT at edge 2.
- `key_state[i]` rises and `key_press[i]` is high for exactly the cycle following edge `DEBOUNCE_CYCLES+2`.
- Release latency is identical, measured from the first sampled `key_n[i] = 1`.

**Glitch rejection**

- A low excursion of `DEBOUNCE_CYCLES-1` or fewer sampled cycles produces no output change.
- An excursion of exactly `DEBOUNCE_CYCLES` sampled cycles is accepted.

**Key held through reset**

- After `rst` deasserts, the synchroniser reloads from the pin.
- A still-held key is reported as a fresh press, with `key_press` at edge `DEBOUNCE_CYCLES+2` after the first post-reset sample.

**Throughput**

- Back-to-back accepted press and release pulses on one key are separated by at least `DEBOUNCE_CYCLES+1` cycles.

## Test plan

All scenarios use `DEBOUNCE_CYCLES = 4` in simulation.

1. Reset: hold `rst` for 3 cycles with `key_n = 4'b0000` -> all outputs 0 during reset. After release, `key_state = 4'b1111` and `key_press = 4'b1111` for one cycle, at edge 6 after the first post-reset sample.
2. Clean press on key 0: drop `key_n[0]` at edge 0 and hold -> `key_press = 4'b0001` for one cycle after edge 6, and `key_state[0] = 1` from then on. Raise it 20 cycles later -> `key_release = 4'b0001` one cycle, 6 edges after the first high sample.
3. Bounce: key 1 toggles low 3 cycles / high 2 / low 3 / high -> no pulses and `key_state[1]` stays 0. Then hold low 4 cycles -> exactly one `key_press[1]` pulse.
4. Release bounce: key 2 in PRESSED goes high 3 cycles, then low -> no `key_release`, `key_state[2]` stays 1, and no second `key_press`.
5. Simultaneous: keys 0 and 3 pressed on the same edge -> `key_press = 4'b1001` in a single cycle. Meanwhile key 1 releases in the same cycle -> `key_release = 4'b0010` concurrently.
6. Reset mid-count: assert `rst` while key 0 is in PRESS_WAIT with `cnt = 2` -> no pulse and outputs 0. After reset with key still held -> press accepted 6 edges after the first post-reset sample.
